// File: rtl/dsi_pkg.sv
// dsi_pkg: DSI data-type codes and line scheduler state encoding
package dsi_pkg;
    localparam logic [5:0] DT_VSS    = 6'h01;
    localparam logic [5:0] DT_VSE    = 6'h11;
    localparam logic [5:0] DT_HSS    = 6'h21;
    localparam logic [5:0] DT_HSE    = 6'h31;
    localparam logic [5:0] DT_RGB888 = 6'h3E;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHORT,
        ST_GAP,
        ST_LONG,
        ST_HOLD
    } state_e;
endpackage

// File: rtl/dsi_line_timer.sv
// dsi_line_timer: per-line cycle counter and line index within the frame
module dsi_line_timer
    import dsi_pkg::*;
#(
    parameter logic [15:0] LINE_PERIOD = 16'd600,
    parameter int          LINES       = 245
) (
    input  logic        byte_clk,
    input  logic        reset_n,
    input  logic        run,
    output logic [15:0] timer,
    output logic [10:0] line_idx,
    output logic        line_end,
    output logic        frame_end
);
    logic [15:0] timer_q, timer_d;
    logic [10:0] line_q, line_d;

    always_comb begin
        line_end  = timer_q == LINE_PERIOD - 16'd1;
        frame_end = line_end && (line_q == 11'(LINES - 1));
        timer_d   = (!run || line_end) ? '0 : timer_q + 16'd1;
        line_d    = (!run || frame_end) ? '0 : line_end ? line_q + 11'd1 : line_q;
    end

    always_ff @(posedge byte_clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_q <= '0;
            line_q  <= '0;
        end else begin
            timer_q <= timer_d;
            line_q  <= line_d;
        end
    end

    assign timer    = timer_q;
    assign line_idx = line_q;
endmodule

// File: rtl/dsi_line_scheduler.sv
// dsi_line_scheduler: sequences DSI sync short packets and RGB888 long packets per video line
module dsi_line_scheduler
    import dsi_pkg::*;
#(
    parameter int          LANES       = 4,
    parameter logic [15:0] WC          = 16'd720,
    parameter logic [15:0] LINE_PERIOD = 16'd600,
    parameter logic [15:0] HDLY        = 16'd24,
    parameter int          SHORT_HOLD  = 2,
    parameter int          VSA         = 1,
    parameter int          VBP         = 2,
    parameter int          VACT        = 240,
    parameter int          VFP         = 2,
    parameter logic [1:0]  VC          = 2'd0
) (
    input  logic        byte_clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic        short_en,
    output logic        long_en,
    output logic [1:0]  vc,
    output logic [5:0]  dt,
    output logic [15:0] wc,
    output logic        pix_req,
    output logic [10:0] line_idx,
    output logic        frame_done,
    output logic        busy
);
    localparam int          LINES     = VSA + VBP + VACT + VFP;
    localparam int          FIRST_ACT = VSA + VBP;
    localparam int          LAST_ACT  = FIRST_ACT + VACT - 1;
    localparam logic [15:0] BEATS     = WC / 16'(LANES);
    localparam logic [15:0] SHORT_END = 16'(SHORT_HOLD - 1);
    localparam logic [15:0] GAP_END   = HDLY - 16'd1;
    localparam logic [15:0] LONG_END  = HDLY + BEATS - 16'd1;
    localparam logic [15:0] PRE_END   = LINE_PERIOD - 16'd2;

    if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
        $error("LANES must be 1, 2 or 4");
    end
    if (WC == 16'd0 || (WC % 16'(LANES)) != 16'd0) begin : g_bad_wc
        $error("WC must be a nonzero multiple of LANES");
    end
    if (HDLY < 16'd20 || SHORT_HOLD < 2 || 16'(SHORT_HOLD) >= HDLY) begin : g_bad_hdly
        $error("HDLY must be >= 20 and SHORT_HOLD in [2, HDLY-1]");
    end
    if (LINE_PERIOD < HDLY + BEATS + 16'd24) begin : g_bad_period
        $error("LINE_PERIOD too short for HDLY and payload");
    end
    if (VSA < 1 || VBP < 1 || VACT < 1 || VFP < 1 || LINES > 2048) begin : g_bad_lines
        $error("vertical region counts must be >= 1 and total <= 2048");
    end

    state_e      state_q, state_d;
    logic [5:0]  dt_q, dt_d, next_dt;
    logic [15:0] wc_q, wc_d;
    logic        frame_done_q, frame_done_d;
    logic [15:0] timer;
    logic        line_end, frame_end, active, last_line;

    dsi_line_timer #(
        .LINE_PERIOD(LINE_PERIOD),
        .LINES      (LINES)
    ) u_timer (
        .byte_clk (byte_clk),
        .reset_n  (reset_n),
        .run      (busy),
        .timer    (timer),
        .line_idx (line_idx),
        .line_end (line_end),
        .frame_end(frame_end)
    );

    assign active    = line_idx >= 11'(FIRST_ACT) && line_idx <= 11'(LAST_ACT);
    assign last_line = line_idx == 11'(LINES - 1);

    // dt/wc switch as the previous request falls, so they lead the next rising edge
    always_comb begin
        state_d      = state_q;
        dt_d         = dt_q;
        wc_d         = wc_q;
        next_dt      = last_line ? DT_VSS : DT_HSS;
        frame_done_d = state_q == ST_HOLD && last_line && timer == PRE_END;
        case (state_q)
            ST_IDLE: begin
                dt_d    = DT_VSS;
                wc_d    = '0;
                state_d = enable ? ST_SHORT : ST_IDLE;
            end
            ST_SHORT: if (timer == SHORT_END) begin
                state_d = active ? ST_GAP : ST_HOLD;
                dt_d    = active ? DT_RGB888 : next_dt;
                wc_d    = active ? WC : '0;
            end
            ST_GAP: if (timer == GAP_END) state_d = ST_LONG;
            ST_LONG: if (timer == LONG_END) begin
                state_d = ST_HOLD;
                dt_d    = next_dt;
                wc_d    = '0;
            end
            ST_HOLD: if (line_end) state_d = (frame_end && !enable) ? ST_IDLE : ST_SHORT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge byte_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            dt_q         <= '0;
            wc_q         <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dt_q         <= dt_d;
            wc_q         <= wc_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign short_en   = state_q == ST_SHORT;
    assign long_en    = state_q == ST_LONG;
    assign pix_req    = long_en;
    assign busy       = state_q != ST_IDLE;
    assign vc         = VC;
    assign dt         = dt_q;
    assign wc         = wc_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_dsi_line_scheduler.sv
// tb_dsi_line_scheduler: small-frame scheduler checks for LANES 4/2/1 against a frame-position model
module tb_dsi_line_scheduler;
    localparam int LP    = 64;
    localparam int HD    = 20;
    localparam int SH    = 2;
    localparam int LINES = 5;
    localparam int FRAME = LP * LINES;

    typedef struct {
        int          cyc;
        logic        s;
        logic        l;
        logic        fd;
        logic [5:0]  dt;
        logic [15:0] wc;
        logic [10:0] ln;
    } vec_t;

    logic byte_clk = 1'b0;
    logic reset_n  = 1'b0;
    logic enable   = 1'b0;
    logic        se [3];
    logic        le [3];
    logic        pr [3];
    logic [1:0]  vcv[3];
    logic [5:0]  dtv[3];
    logic [15:0] wcv[3];
    logic [10:0] idx[3];
    logic        fd [3];
    logic        bz [3];

    int   checks = 0;
    int   errors = 0;
    int   pos    = -1;
    bit   mon_on = 1'b0;
    int   cur;
    int   cnt[3];
    vec_t vt[$];

    always #5 byte_clk = ~byte_clk;

    for (genvar i = 0; i < 3; i++) begin : g_dut
        dsi_line_scheduler #(
            .LANES      (i == 0 ? 4 : i == 1 ? 2 : 1),
            .WC         (16'd16),
            .LINE_PERIOD(16'd64),
            .HDLY       (16'd20),
            .SHORT_HOLD (2),
            .VSA        (1),
            .VBP        (1),
            .VACT       (2),
            .VFP        (1),
            .VC         (2'(i))
        ) u_dut (
            .byte_clk  (byte_clk),
            .reset_n   (reset_n),
            .enable    (enable),
            .short_en  (se[i]),
            .long_en   (le[i]),
            .vc        (vcv[i]),
            .dt        (dtv[i]),
            .wc        (wcv[i]),
            .pix_req   (pr[i]),
            .line_idx  (idx[i]),
            .frame_done(fd[i]),
            .busy      (bz[i])
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // frame position model: -1 idle, else cycle index within the frame
    always @(posedge byte_clk or negedge reset_n) begin
        if (!reset_n) pos <= -1;
        else if (pos < 0 || pos == FRAME - 1) pos <= enable ? 0 : -1;
        else pos <= pos + 1;
    end

    always @(negedge byte_clk) begin
        int ln, t, n;
        bit b, act, s, l;
        logic [5:0] sdt;
        if (mon_on) begin
            for (int i = 0; i < 3; i++) begin
                b   = pos >= 0;
                ln  = b ? pos / LP : 0;
                t   = b ? pos % LP : 0;
                n   = i == 0 ? 4 : i == 1 ? 8 : 16;
                act = ln == 2 || ln == 3;
                s   = b && t < SH;
                l   = b && act && t >= HD && t < HD + n;
                chk($sformatf("ctl%0d", i), {se[i], le[i], pr[i], bz[i], fd[i], idx[i]},
                    {s, l, l, b, b && pos == FRAME - 1, 11'(ln)});
                sdt = (t == LP - 1) ? ((ln == LINES - 1) ? 6'h01 : 6'h21) : ((ln == 0) ? 6'h01 : 6'h21);
                if (s || (b && t == LP - 1)) chk($sformatf("short_dtwc%0d", i), {dtv[i], wcv[i]}, {sdt, 16'd0});
                if (l || (b && act && t == HD - 1)) chk($sformatf("long_dtwc%0d", i), {dtv[i], wcv[i]}, {6'h3E, 16'd16});
            end
        end
    end

    initial begin
        vt.push_back('{0,   1, 0, 0, 6'h01, 16'd0,  11'd0});
        vt.push_back('{1,   1, 0, 0, 6'h01, 16'd0,  11'd0});
        vt.push_back('{2,   0, 0, 0, 6'h21, 16'd0,  11'd0});
        vt.push_back('{64,  1, 0, 0, 6'h21, 16'd0,  11'd1});
        vt.push_back('{128, 1, 0, 0, 6'h21, 16'd0,  11'd2});
        vt.push_back('{130, 0, 0, 0, 6'h3E, 16'd16, 11'd2});
        vt.push_back('{147, 0, 0, 0, 6'h3E, 16'd16, 11'd2});
        vt.push_back('{148, 0, 1, 0, 6'h3E, 16'd16, 11'd2});
        vt.push_back('{151, 0, 1, 0, 6'h3E, 16'd16, 11'd2});
        vt.push_back('{152, 0, 0, 0, 6'h21, 16'd0,  11'd2});
        vt.push_back('{212, 0, 1, 0, 6'h3E, 16'd16, 11'd3});
        vt.push_back('{256, 1, 0, 0, 6'h21, 16'd0,  11'd4});
        vt.push_back('{258, 0, 0, 0, 6'h01, 16'd0,  11'd4});
        vt.push_back('{319, 0, 0, 1, 6'h01, 16'd0,  11'd4});
        vt.push_back('{320, 1, 0, 0, 6'h01, 16'd0,  11'd0});
        vt.push_back('{640, 1, 0, 0, 6'h01, 16'd0,  11'd0});
        vt.push_back('{959, 0, 0, 1, 6'h01, 16'd0,  11'd4});
        vt.push_back('{960, 1, 0, 0, 6'h01, 16'd0,  11'd0});

        reset_n = 1'b0;
        enable  = 1'b1;
        repeat (3) @(posedge byte_clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_out%0d", i),
                {se[i], le[i], pr[i], bz[i], fd[i], idx[i], dtv[i], wcv[i]}, 32'd0);
            chk($sformatf("reset_vc%0d", i), 32'(vcv[i]), 32'(i));
        end
        mon_on = 1'b1;

        @(posedge byte_clk);
        #2 reset_n = 1'b1;
        @(posedge byte_clk);
        cur = 0;
        for (int k = 0; k < vt.size(); k++) begin
            while (cur < vt[k].cyc) begin
                @(posedge byte_clk);
                cur++;
            end
            @(negedge byte_clk);
            chk($sformatf("vec%0d_ctl", vt[k].cyc), {se[0], le[0], fd[0], idx[0]},
                {vt[k].s, vt[k].l, vt[k].fd, vt[k].ln});
            chk($sformatf("vec%0d_dtwc", vt[k].cyc), {dtv[0], wcv[0]}, {vt[k].dt, vt[k].wc});
        end

        // enable dropped on line 1 of the fourth frame
        while (cur < 1030) begin
            @(posedge byte_clk);
            cur++;
        end
        #2 enable = 1'b0;
        while (cur < 1279) begin
            @(posedge byte_clk);
            cur++;
        end
        @(negedge byte_clk);
        chk("drop_frame_done", {fd[0], idx[0]}, {1'b1, 11'd4});
        @(negedge byte_clk);
        chk("drop_idle", {bz[0], se[0]}, 32'd0);
        cnt[0] = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge byte_clk);
            cnt[0] += int'(se[0] | bz[0]);
        end
        chk("drop_no_short", 32'(cnt[0]), 32'd0);

        // reset on the second LONG cycle
        @(posedge byte_clk);
        #2 enable = 1'b1;
        @(posedge byte_clk);
        cur = 0;
        while (cur < 149) begin
            @(posedge byte_clk);
            cur++;
        end
        #1;
        chk("long_before_reset", {le[0], pr[0]}, 32'd3);
        #1 reset_n = 1'b0;
        #1;
        chk("long_reset_drop", {le[0], pr[0], bz[0]}, 32'd0);
        @(posedge byte_clk);
        #2 reset_n = 1'b1;
        @(posedge byte_clk);
        @(negedge byte_clk);
        chk("restart_vss", {se[0], dtv[0], idx[0]}, {1'b1, 6'h01, 11'd0});

        // payload beats per frame for LANES 4/2/1
        for (int i = 0; i < 3; i++) cnt[i] = 0;
        for (int c = 0; c < FRAME; c++) begin
            for (int i = 0; i < 3; i++) cnt[i] += int'(pr[i]);
            @(negedge byte_clk);
        end
        chk("beats_lanes4", 32'(cnt[0]), 32'd8);
        chk("beats_lanes2", 32'(cnt[1]), 32'd16);
        chk("beats_lanes1", 32'(cnt[2]), 32'd32);

        for (int k = 0; k < 6000; k++) begin
            @(posedge byte_clk);
            #2;
            if ($urandom_range(0, 299) == 0) enable = ~enable;
            reset_n = $urandom_range(0, 1499) != 0;
        end
        reset_n = 1'b1;
        @(negedge byte_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
